// File: rtl/glhf_pkg.sv
// rtl/glhf_pkg.sv - shared types, defaults and helpers for the glhf pattern engine
package glhf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } glhf_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_DIVW  = 8;
    localparam int DEF_CNTW  = 8;

    // Address width for n entries, never below one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/glhf_pattern_mem.sv
// rtl/glhf_pattern_mem.sv - DEPTH x WIDTH array, synchronous write, combinational read
module glhf_pattern_mem
    import glhf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = clog2_min1(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/glhf_pattern_engine.sv
// rtl/glhf_pattern_engine.sv - pin self-test pattern player/checker; GLHF_CAPTURE_EN adds a capture array
module glhf_pattern_engine
    import glhf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int DIVW  = DEF_DIVW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          ena_i,
    input  logic                          wr_en_i,
    input  logic [WIDTH-1:0]              wr_data_i,
    input  logic                          clr_i,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic                          loop_mode_i,
    input  logic [DIVW-1:0]               div_i,
    output logic [WIDTH-1:0]              pat_out_o,
    output logic [WIDTH-1:0]              pat_oe_o,
    input  logic [WIDTH-1:0]              cap_in_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [CNTW-1:0]               err_cnt_o,
    output logic                          err_flag_o,
    input  logic [clog2_min1(DEPTH)-1:0]  rd_addr_i,
    output logic [WIDTH-1:0]              rd_data_o
);

    localparam int AW = clog2_min1(DEPTH);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    glhf_state_e      state_q, state_d;
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW:0]      len_q, len_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [DIVW-1:0]  hold_q, hold_d;
    logic [DIVW-1:0]  div_q, div_d;
    logic [WIDTH-1:0] pat_out_q, pat_out_d;
    logic [WIDTH-1:0] pat_oe_q, pat_oe_d;
    logic [CNTW-1:0]  err_cnt_q, err_cnt_d;
    logic             err_flag_q, err_flag_d;

    logic             mem_we;
    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;
    logic             last_entry;

    assign last_entry = ({1'b0, rp_q} == (len_q - 1'b1));
    // Read port serves both start/loop (entry 0) and advance (rp+1).
    assign mem_raddr  = (state_q == ST_RUN && !last_entry) ? rp_q + 1'b1 : '0;

    glhf_pattern_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_pat_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we && ena_i),
        .waddr_i (wp_q),
        .wdata_i (wr_data_i),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        len_d      = len_q;
        rp_d       = rp_q;
        hold_d     = hold_q;
        div_d      = div_q;
        pat_out_d  = pat_out_q;
        pat_oe_d   = pat_oe_q;
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q;
        mem_we     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i && len_q != '0) begin
                    state_d    = ST_RUN;
                    rp_d       = '0;
                    pat_out_d  = mem_rdata;
                    pat_oe_d   = '1;
                    err_cnt_d  = '0;
                    err_flag_d = 1'b0;
                    div_d      = div_i;
                    hold_d     = div_i;
                end else if (clr_i) begin
                    wp_d    = '0;
                    len_d   = '0;
                    state_d = ST_IDLE;
                end else if (wr_en_i) begin
                    mem_we  = 1'b1;
                    wp_d    = wp_q + 1'b1;
                    state_d = ST_IDLE;
                    if (len_q != LEN_MAX) begin
                        len_d = len_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d  = ST_IDLE;
                    pat_oe_d = '0;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else begin
                    if (cap_in_i != pat_out_q) begin
                        err_flag_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                    hold_d = div_q;
                    if (!last_entry) begin
                        rp_d      = rp_q + 1'b1;
                        pat_out_d = mem_rdata;
                    end else if (loop_mode_i) begin
                        rp_d      = '0;
                        pat_out_d = mem_rdata;
                    end else begin
                        state_d  = ST_DONE;
                        pat_oe_d = '0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                pat_oe_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wp_q       <= '0;
            len_q      <= '0;
            rp_q       <= '0;
            hold_q     <= '0;
            div_q      <= '0;
            pat_out_q  <= '0;
            pat_oe_q   <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else if (ena_i) begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            len_q      <= len_d;
            rp_q       <= rp_d;
            hold_q     <= hold_d;
            div_q      <= div_d;
            pat_out_q  <= pat_out_d;
            pat_oe_q   <= pat_oe_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign pat_out_o  = pat_out_q;
    assign pat_oe_o   = pat_oe_q;
    assign busy_o     = (state_q == ST_RUN);
    assign done_o     = (state_q == ST_DONE);
    assign err_cnt_o  = err_cnt_q;
    assign err_flag_o = err_flag_q;

`ifdef GLHF_CAPTURE_EN
    logic             cap_we;
    logic [WIDTH-1:0] cap_rdata;
    logic [WIDTH-1:0] rd_data_q;

    assign cap_we = ena_i && (state_q == ST_RUN) && !stop_i && (hold_q == '0);

    glhf_pattern_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_cap_mem (
        .clk_i   (clk_i),
        .we_i    (cap_we),
        .waddr_i (rp_q),
        .wdata_i (cap_in_i),
        .raddr_i (rd_addr_i),
        .rdata_o (cap_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (ena_i) begin
            rd_data_q <= cap_rdata;
        end
    end

    assign rd_data_o = rd_data_q;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr_i;
    assign rd_data_o      = '0;
`endif

endmodule

// File: tb/tb_glhf_pattern_engine.sv
// tb/tb_glhf_pattern_engine.sv - directed self-checking bench for glhf_pattern_engine
module tb_glhf_pattern_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr;
    logic       start;
    logic       stop;
    logic       loop_mode;
    logic [7:0] div;
    logic [7:0] cap_in;
    logic [3:0] rd_addr;
    logic [1:0] cap_mode;

    logic [7:0] pat_out, pat_oe, rd_data, err_cnt;
    logic       busy, done, err_flag;
    logic [7:0] pat_out2, pat_oe2, rd_data2;
    logic [1:0] err_cnt2;
    logic       busy2, done2, err_flag2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign cap_in = (cap_mode == 2'd0) ? pat_out :
                    (cap_mode == 2'd1) ? 8'h00 : ~pat_out;

    glhf_pattern_engine #(.WIDTH(8), .DEPTH(16), .DIVW(8), .CNTW(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .clr_i(clr), .start_i(start), .stop_i(stop), .loop_mode_i(loop_mode), .div_i(div),
        .pat_out_o(pat_out), .pat_oe_o(pat_oe), .cap_in_i(cap_in), .busy_o(busy),
        .done_o(done), .err_cnt_o(err_cnt), .err_flag_o(err_flag),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data)
    );

    glhf_pattern_engine #(.WIDTH(8), .DEPTH(16), .DIVW(8), .CNTW(2)) u_dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .clr_i(clr), .start_i(start), .stop_i(stop), .loop_mode_i(loop_mode), .div_i(div),
        .pat_out_o(pat_out2), .pat_oe_o(pat_oe2), .cap_in_i(cap_in), .busy_o(busy2),
        .done_o(done2), .err_cnt_o(err_cnt2), .err_flag_o(err_flag2),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [7:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic clear_mem();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr = 1'b0;
        start = 1'b0; stop = 1'b0; loop_mode = 1'b0; div = 8'd0; rd_addr = 4'd0;
        cap_mode = 2'd0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pat_out", pat_out, 8'h00);
        chk("rst_pat_oe", pat_oe, 8'h00);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_rd_data", rd_data, 8'h00);
        rst_n = 1'b1;
        tick();

        // start with empty memory is ignored
        pulse_start();
        chk("empty_start_busy", busy, 0);
        chk("empty_start_oe", pat_oe, 8'h00);

        // loopback one-shot, div=2; coincident and in-run writes are dropped
        write_word(8'h11); write_word(8'h22); write_word(8'h33);
        div = 8'd2; loop_mode = 1'b0; cap_mode = 2'd0;
        start = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        tick();
        start = 1'b0;
        chk("lb_k0_busy", busy, 1);
        chk("lb_k0_pat", pat_out, 8'h11);
        chk("lb_k0_oe", pat_oe, 8'hFF);
        tick(); tick();
        wr_en = 1'b0;
        chk("lb_k2_pat", pat_out, 8'h11);
        tick();
        chk("lb_k3_pat", pat_out, 8'h22);
        tick(); tick(); tick();
        chk("lb_k6_pat", pat_out, 8'h33);
        tick(); tick();
        chk("lb_k8_busy", busy, 1);
        tick();
        chk("lb_k9_done", done, 1);
        chk("lb_k9_busy", busy, 0);
        chk("lb_k9_oe", pat_oe, 8'h00);
        chk("lb_k9_pat_hold", pat_out, 8'h33);
        chk("lb_err_cnt", err_cnt, 0);
        chk("lb_err_flag", err_flag, 0);

        // mismatches, div=0; length still 3 proves dropped writes
        div = 8'd0; cap_mode = 2'd1;
        pulse_start();
        chk("mm_k0_err", err_cnt, 0);
        chk("mm_k0_pat", pat_out, 8'h11);
        tick();
        chk("mm_k1_err", err_cnt, 1);
        chk("mm_k1_pat", pat_out, 8'h22);
        tick();
        chk("mm_k2_busy", busy, 1);
        tick();
        chk("mm_k3_done", done, 1);
        chk("mm_err_cnt", err_cnt, 3);
        chk("mm_err_flag", err_flag, 1);
        chk("mm_err_cnt_sat", err_cnt2, 3);

        // saturation: five mismatches on a 2-bit counter
        clear_mem();
        for (int i = 1; i <= 5; i++) write_word(8'(i));
        pulse_start();
        chk("sat_k0_err_clr", err_cnt, 0);
        chk("sat_k0_flag_clr", err_flag, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_done", done, 1);
        chk("sat_err8", err_cnt, 5);
        chk("sat_err2", err_cnt2, 3);

        // looping two entries, then stop
        clear_mem();
        write_word(8'hA5); write_word(8'h5A);
        div = 8'd0; loop_mode = 1'b1; cap_mode = 2'd0;
        pulse_start();
        chk("loop_k0_pat", pat_out, 8'hA5);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("loop_k%0d_pat", k), pat_out, (k % 2 == 0) ? 8'hA5 : 8'h5A);
        end
        chk("loop_busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        chk("stop_oe", pat_oe, 8'h00);
        chk("stop_err", err_cnt, 0);

        // ena low for five cycles mid-run stretches the run by five
        loop_mode = 1'b0; div = 8'd1;
        pulse_start();
        tick();
        ena = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("ena_frz_pat", pat_out, 8'hA5);
        chk("ena_frz_busy", busy, 1);
        ena = 1'b1;
        tick();
        chk("ena_e7_pat", pat_out, 8'h5A);
        tick();
        chk("ena_e8_busy", busy, 1);
        tick();
        chk("ena_e9_done", done, 1);

        // 17 writes into 16 entries: length saturates, word 17 overwrites entry 0
        clear_mem();
        for (int i = 0; i < 17; i++) write_word(8'(8'h40 + i));
        div = 8'd0;
        pulse_start();
        chk("wrap_k0_pat", pat_out, 8'h50);
        tick();
        chk("wrap_k1_pat", pat_out, 8'h41);
        for (int i = 0; i < 14; i++) tick();
        chk("wrap_k15_pat", pat_out, 8'h4F);
        chk("wrap_k15_busy", busy, 1);
        tick();
        chk("wrap_k16_done", done, 1);

        // capture path with inverted return bus
        clear_mem();
        write_word(8'h0F); write_word(8'hF0); write_word(8'h3C); write_word(8'hC3);
        cap_mode = 2'd2;
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        chk("cap_done", done, 1);
        chk("cap_err", err_cnt, 4);
        rd_addr = 4'd2;
        tick();
`ifdef GLHF_CAPTURE_EN
        chk("cap_rd_data", rd_data, 8'hC3);
`else
        chk("cap_rd_data_off", rd_data, 8'h00);
`endif

        // asynchronous reset in the middle of a looping run
        loop_mode = 1'b1;
        pulse_start();
        tick(); tick();
        chk("arst_pre_err", err_cnt, 2);
        chk("arst_pre_oe", pat_oe, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_oe", pat_oe, 8'h00);
        chk("arst_busy", busy, 0);
        chk("arst_err", err_cnt, 0);
        chk("arst_flag", err_flag, 0);
        tick();
        rst_n = 1'b1;
        loop_mode = 1'b0;
        tick();
        chk("arst_pat_out", pat_out, 8'h00);
        pulse_start();
        chk("arst_len_zero", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
